fir_mc: RTL and testbench
=========================

FIR_MC -- requirements
Module: fir_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed input sample width.
REQ-002 SHALL have parameter COEF_W, default 16, signed coefficient width.
REQ-003 SHALL have parameter NUM_TAPS, default 10, taps per channel (legal range 2..256).
REQ-004 SHALL have parameter NUM_CH, default 2, number of independent channels (legal range 1..16).
REQ-005 SHALL have parameter OUT_W, default 16, signed output width, at most ACC_W = DATA_W+COEF_W+$clog2(NUM_TAPS).
REQ-006 SHALL have parameter OUT_SHIFT, default 0, arithmetic right shift applied to the accumulator before saturation.
REQ-007 SHALL have port i_clk, input, 1, sole clock (all logic on rising edge).
REQ-008 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port i_data, input, NUM_CH*DATA_W, sample vector (channel c at bits [c*DATA_W +: DATA_W]).
REQ-010 SHALL have port i_valid, input, 1, sample vector valid.
REQ-011 SHALL have port o_ready, output, 1, high only in IDLE; sample accepted on an edge where i_valid && o_ready.
REQ-012 SHALL have port i_coef_wr, input, 1, coefficient write strobe.
REQ-013 SHALL have port i_coef_addr, input, $clog2(NUM_TAPS), tap index.
REQ-014 SHALL have port i_coef_data, input, COEF_W, signed coefficient (shared by all channels).
REQ-015 SHALL have port o_coef_err, output, 1, one-cycle pulse on a rejected coefficient write.
REQ-016 SHALL have port o_data, output, OUT_W, filtered result.
REQ-017 SHALL have port o_ch, output, $clog2(NUM_CH) (min 1), channel of o_data.
REQ-018 SHALL have port o_valid, output, 1, one-cycle pulse qualifying o_data/o_ch.
REQ-019 SHALL have port o_sat, output, 1, high with o_valid when the result was clipped.

Function
REQ-020 SHALL implement FSM IDLE -> MAC -> IDLE; one multiply-accumulate per cycle, one shared multiplier.
REQ-021 On accept at edge T: each channel's delay line shifts (new sample at tap 0, oldest sample discarded); state becomes MAC with ch=0, tap=0, acc=0.
REQ-022 In MAC, edge T+c*NUM_TAPS+k+1 (k = 0..NUM_TAPS-1) SHALL add coef[k]*x_c[k] to a full-precision ACC_W accumulator.
REQ-023 On the edge adding tap NUM_TAPS-1 for channel c, the block SHALL load o_data/o_ch=c/o_sat, pulse o_valid, clear acc, and advance to channel c+1.
REQ-024 After the last channel's result edge (T+NUM_CH*NUM_TAPS), state SHALL return to IDLE, raising o_ready; accept-to-accept interval is at minimum NUM_CH*NUM_TAPS+1 cycles.
REQ-025 Output arithmetic: if OUT_SHIFT>0, add 2^(OUT_SHIFT-1) then shift right arithmetically (round half up); saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1], setting o_sat on a clip.
REQ-026 Coefficient write SHALL take effect at the edge only when o_ready=1 and i_coef_addr<NUM_TAPS; otherwise it is dropped and o_coef_err pulses on the next cycle.
REQ-027 A simultaneous accept and coefficient write in IDLE SHALL both take effect; the accepted vector SHALL use the new coefficient.
REQ-028 i_valid while o_ready=0 SHALL be ignored (no buffering, no state change).
REQ-029 o_data, o_ch and o_sat SHALL hold their last values between o_valid pulses.

Reset
REQ-030 i_rst_n low SHALL immediately force IDLE, clear acc, counters, all delay lines, o_data, o_ch, o_valid, o_sat, o_coef_err to 0; o_ready=1 once in IDLE.
REQ-031 Reset SHALL load coef[0]=1 and all other coefficients with 0 (pass-through); reset mid-MAC SHALL abort with no o_valid pulse.

Verification
REQ-032 Post-reset pass-through: inputs ch0=100, ch1=-5 -> o_valid at T+10 (o_ch=0, o_data=100), T+20 (o_ch=1, o_data=-5); o_ready high at T+20.
REQ-033 Impulse response: write coefs 10,0,0,-3,12,-4,12,1,0,-3; feed ch0 = 1 then nine zeros -> ch0 outputs 10,0,0,-3,12,-4,12,1,0,-3; ch1 outputs all 0.
REQ-034 Saturation: all coefs 32767, repeated input 32767 -> o_data=32767 with o_sat=1 from the first output; repeated input -32768 -> o_data=-32768 with o_sat=1.
REQ-035 Rounding: OUT_SHIFT=2, coef[0]=1, input 6 -> 2; input -6 -> -1; o_sat=0.
REQ-036 Rejected writes: coefficient write during MAC, or with addr=10 in IDLE -> o_coef_err pulse, coefficients unchanged, subsequent results identical to before.
REQ-037 Reset at T+5 mid-MAC -> no o_valid, outputs 0, o_ready=1; next vector behaves as pass-through with cleared history.

Source files
------------

// File: rtl/fir_mc.sv
// Multi-channel FIR filter: one shared multiplier steps through every tap of every
// channel in turn, then rounds, saturates and emits one result per channel.
module fir_mc #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 16,
  parameter int unsigned NUM_TAPS  = 10,
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [NUM_CH*DATA_W-1:0]               i_data,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic                                   i_coef_wr,
  input  logic [$clog2(NUM_TAPS)-1:0]            i_coef_addr,
  input  logic [COEF_W-1:0]                      i_coef_data,
  output logic                                   o_coef_err,
  output logic [OUT_W-1:0]                       o_data,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_ch,
  output logic                                   o_valid,
  output logic                                   o_sat
);

  localparam int unsigned TAP_W  = $clog2(NUM_TAPS);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_TAPS);
  localparam int unsigned RND_W  = ACC_W + 1;
  localparam int unsigned RND_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

  localparam logic signed [RND_W-1:0] RND_ADD =
    (OUT_SHIFT > 0) ? (RND_W'(1) << RND_SH) : '0;
  localparam logic signed [RND_W-1:0] SAT_MAX =
    RND_W'((RND_W'(1) << (OUT_W - 1)) - RND_W'(1));
  localparam logic signed [RND_W-1:0] SAT_MIN = ~SAT_MAX;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic signed [DATA_W-1:0] dly_q  [NUM_CH][NUM_TAPS];
  logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [TAP_W-1:0]         tap_q;
  logic [CH_W-1:0]          ch_q;

  logic accept;
  logic mac_en;
  logic result_en;
  logic last_step;
  logic coef_ok;

  logic signed [DATA_W-1:0] smp_sel;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [RND_W-1:0]  rnd;
  logic                     sat_hi;
  logic                     sat_lo;
  logic [OUT_W-1:0]         res;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_valid)   state_d = ST_MAC;
      ST_MAC:  if (last_step) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Control decode; coefficients may only change while no MAC sequence is running
  always_comb begin
    o_ready   = 1'b0;
    accept    = 1'b0;
    mac_en    = 1'b0;
    result_en = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
      end
      ST_MAC: begin
        mac_en    = 1'b1;
        result_en = (tap_q == LAST_TAP);
        last_step = (tap_q == LAST_TAP) && (ch_q == LAST_CH);
      end
      default: ;
    endcase
    coef_ok = i_coef_wr && o_ready && (32'(i_coef_addr) < NUM_TAPS);
  end

  // Shared multiplier, full-precision accumulate, round half up, saturate
  always_comb begin
    smp_sel  = dly_q[ch_q][tap_q];
    coef_sel = coef_q[tap_q];
    prod     = PROD_W'(coef_sel) * PROD_W'(smp_sel);
    acc_sum  = acc_q + ACC_W'(prod);
    rnd      = (RND_W'(acc_sum) + RND_ADD) >>> OUT_SHIFT;
    sat_hi   = (rnd > SAT_MAX);
    sat_lo   = (rnd < SAT_MIN);
    if (sat_hi) begin
      res = OUT_W'(SAT_MAX);
    end else if (sat_lo) begin
      res = OUT_W'(SAT_MIN);
    end else begin
      res = OUT_W'(rnd);
    end
  end

  // Datapath: delay lines, coefficient bank, accumulator, counters, outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
          dly_q[c][k] <= '0;
        end
      end
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        coef_q[k] <= (k == 0) ? COEF_W'(1) : '0;
      end
      acc_q      <= '0;
      tap_q      <= '0;
      ch_q       <= '0;
      o_data     <= '0;
      o_ch       <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
      o_coef_err <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_coef_err <= i_coef_wr && !coef_ok;

      if (coef_ok) begin
        coef_q[i_coef_addr] <= i_coef_data;
      end

      if (accept) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          dly_q[c][0] <= i_data[c*DATA_W +: DATA_W];
          for (int unsigned k = 1; k < NUM_TAPS; k++) begin
            dly_q[c][k] <= dly_q[c][k-1];
          end
        end
        acc_q <= '0;
        tap_q <= '0;
        ch_q  <= '0;
      end

      if (mac_en) begin
        if (result_en) begin
          o_data  <= res;
          o_ch    <= ch_q;
          o_sat   <= sat_hi || sat_lo;
          o_valid <= 1'b1;
          acc_q   <= '0;
          tap_q   <= '0;
          ch_q    <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
        end else begin
          acc_q <= acc_sum;
          tap_q <= tap_q + TAP_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mc.sv
// Bench for fir_mc: a default instance and an OUT_SHIFT=2 instance share stimulus;
// a reference model queues expected results and timing, monitors pop and compare.
module tb_fir_mc;

  localparam int NT = 10;
  localparam int NC = 2;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NC*DW-1:0] din;
  logic             vin;
  logic             cwr;
  logic [3:0]       caddr;
  logic [CW-1:0]    cdata;

  logic [OW-1:0] odata [2];
  logic [0:0]    och   [2];
  logic          ov    [2];
  logic          osat  [2];
  logic          ordy  [2];
  logic          ocerr [2];

  fir_mc u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vin), .o_ready(ordy[0]),
    .i_coef_wr(cwr), .i_coef_addr(caddr), .i_coef_data(cdata), .o_coef_err(ocerr[0]),
    .o_data(odata[0]), .o_ch(och[0]), .o_valid(ov[0]), .o_sat(osat[0])
  );

  fir_mc #(.OUT_SHIFT(2)) u_rnd (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(din), .i_valid(vin), .o_ready(ordy[1]),
    .i_coef_wr(cwr), .i_coef_addr(caddr), .i_coef_data(cdata), .o_coef_err(ocerr[1]),
    .o_data(odata[1]), .o_ch(och[1]), .o_valid(ov[1]), .o_sat(osat[1])
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint d;
    int     ch;
    bit     sat;
    int     cyc;
  } exp_t;

  exp_t   q [2][$];
  longint dly_m [NC][NT];
  longint coef_m [NT];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void calc(input longint acc_in, input int sh,
                               output longint r, output bit s);
    longint a;
    a = acc_in;
    if (sh > 0) a = (a + (longint'(1) << (sh - 1))) >>> sh;
    s = 1'b0;
    if (a > 32767) begin
      a = 32767; s = 1'b1;
    end else if (a < -32768) begin
      a = -32768; s = 1'b1;
    end
    r = a;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NT; k++) dly_m[c][k] = 0;
    for (int k = 0; k < NT; k++) coef_m[k] = (k == 0) ? 1 : 0;
  endfunction

  // Output monitor: every o_valid must match the oldest queued prediction
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (ov[i] === 1'b1) begin
        if (q[i].size() == 0) begin
          chk($sformatf("spurious_valid%0d", i), 1, 0);
        end else begin
          e = q[i].pop_front();
          chk($sformatf("data%0d_ch%0d", i, e.ch), longint'($signed(odata[i])), e.d);
          chk($sformatf("och%0d", i), longint'(och[i]), e.ch);
          chk($sformatf("sat%0d_ch%0d", i, e.ch), longint'(osat[i]), e.sat);
          chk($sformatf("latency%0d_ch%0d", i, e.ch), cyc, e.cyc);
          chk($sformatf("ready_at_result%0d", i), longint'(ordy[i]), (e.ch == NC - 1));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (ordy[0] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ordy[0] !== 1'b1) chk("ready_timeout", longint'(ordy[0]), 1);
  endtask

  task automatic send(input longint a, input longint b, input bit w,
                      input int wa, input longint wv);
    exp_t   e;
    longint acc;
    bit     ok;
    wait_idle();
    din   = {DW'(b), DW'(a)};
    vin   = 1'b1;
    ok    = w && (wa < NT);
    cwr   = w;
    caddr = 4'(wa);
    cdata = CW'(wv);
    @(negedge clk);
    vin = 1'b0;
    cwr = 1'b0;
    if (w) begin
      chk("coef_err_accept0", longint'(ocerr[0]), !ok);
      chk("coef_err_accept1", longint'(ocerr[1]), !ok);
    end
    if (ok) coef_m[wa] = wv;
    for (int c = 0; c < NC; c++)
      for (int k = NT - 1; k > 0; k--) dly_m[c][k] = dly_m[c][k-1];
    dly_m[0][0] = a;
    dly_m[1][0] = b;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < NC; c++) begin
        acc = 0;
        for (int k = 0; k < NT; k++) acc += coef_m[k] * dly_m[c][k];
        calc(acc, (i == 0) ? 0 : 2, e.d, e.sat);
        e.ch  = c;
        e.cyc = cyc + (c + 1) * NT;
        q[i].push_back(e);
      end
    end
  endtask

  task automatic wr_coef(input int wa, input longint wv);
    bit ok;
    @(negedge clk);
    ok    = (ordy[0] === 1'b1) && (wa < NT);
    cwr   = 1'b1;
    caddr = 4'(wa);
    cdata = CW'(wv);
    @(negedge clk);
    cwr = 1'b0;
    chk($sformatf("coef_err0_a%0d", wa), longint'(ocerr[0]), !ok);
    chk($sformatf("coef_err1_a%0d", wa), longint'(ocerr[1]), !ok);
    if (ok) coef_m[wa] = wv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    q[0].delete();
    q[1].delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_data%0d", i), longint'(odata[i]), 0);
      chk($sformatf("rst_ch%0d", i), longint'(och[i]), 0);
      chk($sformatf("rst_valid%0d", i), longint'(ov[i]), 0);
      chk($sformatf("rst_sat%0d", i), longint'(osat[i]), 0);
      chk($sformatf("rst_ready%0d", i), longint'(ordy[i]), 1);
      chk($sformatf("rst_cerr%0d", i), longint'(ocerr[i]), 0);
    end
  endtask

  int  n;
  int  impulse [NT] = '{10, 0, 0, -3, 12, -4, 12, 1, 0, -3};

  initial begin
    vin = 1'b0; cwr = 1'b0; caddr = '0; cdata = '0; din = '0;
    model_reset();
    do_reset();

    // Pass-through after reset, then rounding cases
    send(100, -5, 0, 0, 0);
    send(6, -6, 0, 0, 0);
    send(-6, 6, 0, 0, 0);

    // Rejected writes: bad address while idle, any write while busy
    wait_idle();
    wr_coef(10, 77);
    wr_coef(15, -1);
    send(7, -9, 0, 0, 0);
    wr_coef(0, 55);
    send(-1234, 4321, 0, 0, 0);

    // Reset in the middle of a MAC sequence
    send(1, 2, 0, 0, 0);
    repeat (4) @(negedge clk);
    do_reset();
    send(300, -300, 0, 0, 0);

    // Impulse response; last coefficient written together with the accept
    do_reset();
    for (int k = 0; k < NT - 1; k++) wr_coef(k, impulse[k]);
    send(1, 0, 1, NT - 1, impulse[NT-1]);
    for (int j = 0; j < NT - 1; j++) send(0, 0, 0, 0, 0);

    // Valid while busy is ignored
    send(5, -7, 0, 0, 0);
    din = '1;
    vin = 1'b1;
    repeat (5) @(negedge clk);
    vin = 1'b0;
    send(11, 13, 0, 0, 0);

    // Saturation in both directions
    wait_idle();
    for (int k = 0; k < NT; k++) wr_coef(k, 32767);
    for (int j = 0; j < NT; j++) send(32767, 32767, 0, 0, 0);
    for (int j = 0; j < NT + 2; j++) send(-32768, -32768, 0, 0, 0);

    n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q[0].size() + q[1].size(), 0);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
